// File: rtl/bfp_group_accumulator.sv
// Serial group accumulator feeding the BFP-to-FP32 converter: sums GRPSIZE signed products and
// emits sign/magnitude/biased exponent. Optional exponent consistency flag under BFP_EXP_CHECK_EN.
module bfp_group_accumulator #(
  parameter int unsigned GRPSIZE       = 16,
  parameter int unsigned BFPEXPSIZE    = 8,
  parameter int unsigned BFPMANSIZE    = 4,
  parameter int unsigned MULBFPMANSIZE = (BFPMANSIZE - 1) * 2,
  parameter int unsigned LEVELS        = $clog2(GRPSIZE)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic                            i_sign,
  input  logic [MULBFPMANSIZE-1:0]        i_man,
  input  logic [BFPEXPSIZE-1:0]           i_exp_a,
  input  logic [BFPEXPSIZE-1:0]           i_exp_b,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_sign,
  output logic [BFPEXPSIZE:0]             o_exp,
`ifdef BFP_EXP_CHECK_EN
  output logic                            o_exp_err,
`endif
  output logic [MULBFPMANSIZE+LEVELS-1:0] o_man
);

  localparam int unsigned AccW = MULBFPMANSIZE + LEVELS + 1;
  localparam int unsigned OutW = MULBFPMANSIZE + LEVELS;
  localparam int unsigned CntW = LEVELS + 1;
  localparam int unsigned ExpW = BFPEXPSIZE + 1;
  localparam int unsigned SumW = BFPEXPSIZE + 2;
  localparam int unsigned Bias = 2 ** (BFPEXPSIZE - 1) - 1;

  typedef enum logic {StAccum, StHold} state_e;

  state_e                state_q;
  logic signed [AccW-1:0] acc_q;
  logic [CntW-1:0]       cnt_q;
  logic [ExpW-1:0]       exp_q;

  logic                  xfer, first, last;
  logic signed [AccW-1:0] prod, sum;
  logic [OutW-1:0]       abs_sum;
  logic [SumW-1:0]       e_raw;
  logic [ExpW-1:0]       e_sat;

  assign xfer  = i_valid & o_ready;
  assign first = (cnt_q == '0);
  assign last  = (cnt_q == CntW'(GRPSIZE - 1));

  always_comb begin
    prod    = $signed(AccW'(i_man));
    prod    = i_sign ? -prod : prod;
    // First product of a group loads rather than adds, so no clear cycle is needed.
    sum     = first ? prod : acc_q + prod;
    abs_sum = OutW'(sum[AccW-1] ? -sum : sum);
    // SumW-bit signed range tops out at 2^ExpW-1, so only the low clamp is reachable.
    e_raw   = SumW'(i_exp_a) + SumW'(i_exp_b) - SumW'(Bias);
    e_sat   = e_raw[SumW-1] ? '0 : e_raw[ExpW-1:0];
  end

`ifdef BFP_EXP_CHECK_EN
  logic [BFPEXPSIZE-1:0] exp_a_q, exp_b_q;
  logic                  err_q, mismatch;
  assign mismatch = ~first & ({i_exp_a, i_exp_b} != {exp_a_q, exp_b_q});
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_sign    <= 1'b0;
      o_man     <= '0;
      o_exp     <= '0;
`ifdef BFP_EXP_CHECK_EN
      exp_a_q   <= '0;
      exp_b_q   <= '0;
      err_q     <= 1'b0;
      o_exp_err <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StAccum: begin
          if (xfer) begin
            acc_q <= sum;
            cnt_q <= cnt_q + CntW'(1);
            if (first) exp_q <= e_sat;
`ifdef BFP_EXP_CHECK_EN
            if (first) begin
              exp_a_q <= i_exp_a;
              exp_b_q <= i_exp_b;
              err_q   <= 1'b0;
            end else begin
              err_q <= err_q | mismatch;
            end
`endif
            if (last) begin
              state_q   <= StHold;
              o_ready   <= 1'b0;
              o_valid   <= 1'b1;
              o_sign    <= sum[AccW-1];
              o_man     <= abs_sum;
              o_exp     <= exp_q;
`ifdef BFP_EXP_CHECK_EN
              o_exp_err <= err_q | mismatch;
`endif
            end
          end
        end
        StHold: begin
          if (i_ready) begin
            state_q   <= StAccum;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            cnt_q     <= '0;
`ifdef BFP_EXP_CHECK_EN
            err_q     <= 1'b0;
            o_exp_err <= 1'b0;
`endif
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_bfp_group_accumulator.sv
// Scoreboard bench for bfp_group_accumulator: directed groups push expected results, a monitor
// pops and compares on each result handshake.
module tb_bfp_group_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       i_sign = 1'b0;
  logic [5:0] i_man = '0;
  logic [7:0] ea = '0;
  logic [7:0] eb = '0;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic       o_sign;
  logic [8:0] o_exp;
  logic [9:0] o_man;
`ifdef BFP_EXP_CHECK_EN
  logic       o_exp_err;
`endif

  typedef struct {
    logic       s;
    logic [9:0] m;
    logic [8:0] e;
    logic       err;
    string      name;
  } res_t;

  res_t sb[$];
  res_t r;
  int   n_vec = 0;
  int   n_err = 0;

  bfp_group_accumulator dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sign   (i_sign),
    .i_man    (i_man),
    .i_exp_a  (ea),
    .i_exp_b  (eb),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sign   (o_sign),
    .o_exp    (o_exp),
`ifdef BFP_EXP_CHECK_EN
    .o_exp_err(o_exp_err),
`endif
    .o_man    (o_man)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endfunction

  // Monitor: the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got o_man %0d, expected no result", o_man);
      end else begin
        r = sb.pop_front();
        chk({r.name, ".sign"}, int'(o_sign), int'(r.s));
        chk({r.name, ".man"}, int'(o_man), int'(r.m));
        chk({r.name, ".exp"}, int'(o_exp), int'(r.e));
`ifdef BFP_EXP_CHECK_EN
        chk({r.name, ".exp_err"}, int'(o_exp_err), int'(r.err));
`endif
      end
    end
  end

  task automatic expect_res(input string name, input logic s, input int m, input int e,
                            input logic err);
    res_t x;
    x.s = s; x.m = 10'(m); x.e = 9'(e); x.err = err; x.name = name;
    sb.push_back(x);
  endtask

  task automatic send(input logic s, input int m, input int a, input int b);
    int t = 0;
    i_valid = 1'b1; i_sign = s; i_man = 6'(m); ea = 8'(a); eb = 8'(b);
    while (!o_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!o_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: o_ready got 0, expected 1");
    end else begin
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  task automatic group_const(input logic s, input int m, input int a, input int b, input bit g);
    for (int i = 0; i < 16; i++) begin
      send(s, m, a, b);
      gap(g);
    end
  endtask

  task automatic group_mix(input bit g);
    for (int i = 0; i < 16; i++) begin
      if (i < 8) send(1'b0, 49, 130, 120);
      else send(1'b1, 9, 130, 120);
      gap(g);
    end
  endtask

  task automatic group_alt(input bit g);
    for (int i = 0; i < 16; i++) begin
      send(i[0], 7, 100, 100);
      gap(g);
    end
  endtask

  task automatic drain;
    int t = 0;
    while ((sb.size() != 0 || o_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset.o_valid", int'(o_valid), 0);
    chk("reset.o_ready", int'(o_ready), 1);
    chk("reset.o_sign", int'(o_sign), 0);
    chk("reset.o_exp", int'(o_exp), 0);
    chk("reset.o_man", int'(o_man), 0);
    rst_n = 1'b1;

    expect_res("pos49", 1'b0, 784, 127, 1'b0);
    group_const(1'b0, 49, 127, 127, 1'b0);
    chk("pos49.latency_valid", int'(o_valid), 1);
    chk("pos49.latency_ready", int'(o_ready), 0);

    expect_res("mix", 1'b0, 320, 123, 1'b0);
    group_mix(1'b0);
    expect_res("neg1", 1'b1, 16, 127, 1'b0);
    group_const(1'b1, 1, 127, 127, 1'b0);
    expect_res("alt", 1'b0, 0, 73, 1'b0);
    group_alt(1'b0);
    expect_res("mix_gaps", 1'b0, 320, 123, 1'b0);
    group_mix(1'b1);
    expect_res("alt_gaps", 1'b0, 0, 73, 1'b0);
    group_alt(1'b1);
    expect_res("neg49", 1'b1, 784, 127, 1'b0);
    group_const(1'b1, 49, 127, 127, 1'b0);

    // Backpressure: result must hold and the offered product must not be consumed.
    drain();
    i_ready = 1'b0;
    expect_res("bp", 1'b0, 32, 128, 1'b0);
    group_const(1'b0, 2, 127, 128, 1'b0);
    i_valid = 1'b1; i_sign = 1'b0; i_man = 6'd5; ea = 8'd127; eb = 8'd127;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", int'(o_valid), 1);
      chk("bp.hold_ready", int'(o_ready), 0);
      chk("bp.hold_man", int'(o_man), 32);
      chk("bp.hold_exp", int'(o_exp), 128);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_ready", int'(o_ready), 1);
    chk("bp.release_valid", int'(o_valid), 0);
    i_valid = 1'b0;
    expect_res("after_bp", 1'b0, 16, 127, 1'b0);
    group_const(1'b0, 1, 127, 127, 1'b0);

    expect_res("sat_hi", 1'b0, 16, 383, 1'b0);
    group_const(1'b0, 1, 255, 255, 1'b0);
    expect_res("sat_lo", 1'b1, 32, 0, 1'b0);
    group_const(1'b1, 2, 10, 10, 1'b0);

    // Reset mid-group discards the partial sum.
    drain();
    for (int i = 0; i < 7; i++) send(1'b0, 9, 127, 127);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.o_man", int'(o_man), 0);
    chk("midrst.o_ready", int'(o_ready), 1);
    rst_n = 1'b1;
    expect_res("post_rst", 1'b0, 16, 127, 1'b0);
    group_const(1'b0, 1, 127, 127, 1'b0);

    // Reset in HOLD drops the pending result without a handshake.
    drain();
    i_ready = 1'b0;
    group_const(1'b0, 3, 127, 127, 1'b0);
    chk("holdrst.pre_valid", int'(o_valid), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("holdrst.o_valid", int'(o_valid), 0);
    chk("holdrst.o_exp", int'(o_exp), 0);
    rst_n = 1'b1;
    i_ready = 1'b1;
    expect_res("post_holdrst", 1'b0, 16, 127, 1'b0);
    group_const(1'b0, 1, 127, 127, 1'b0);

`ifdef BFP_EXP_CHECK_EN
    expect_res("exp_err", 1'b0, 16, 127, 1'b1);
    for (int i = 0; i < 16; i++) send(1'b0, 1, 127, (i == 4) ? 128 : 127);
    expect_res("exp_ok", 1'b0, 16, 127, 1'b0);
    group_const(1'b0, 1, 127, 127, 1'b0);
`endif

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
